// File: rtl/mpemu_scale_pkg.sv
// Shared constants for the Q8.24 gain multiplier and the mixer sequencer
// that schedules around its fixed latency.
package mpemu_scale_pkg;

    localparam int MPEMU_LATENCY = 6;
    localparam int A_WIDTH       = 24;
    localparam int B_WIDTH       = 32;
    localparam int FRAC_BITS     = 24;
    localparam int P_WIDTH       = 32;

    localparam logic [B_WIDTH-1:0] SCALE_UNITY = 32'h01_000000;

    // The scale is split into a 16-bit unsigned low half and a signed high half.
    localparam int SPLIT_W = 16;
    localparam int PP_LO_W = A_WIDTH + SPLIT_W + 1;
    localparam int PP_HI_W = A_WIDTH + B_WIDTH - SPLIT_W;
    localparam int SUM_W   = A_WIDTH + B_WIDTH;

endpackage

// File: rtl/mpemu_pp.sv
// Registered partial-product multiplier: signed multiplicand times a
// multiplier slice that is treated as either signed or unsigned.
module mpemu_pp
    import mpemu_scale_pkg::*;
#(
    parameter int A_W      = 24,
    parameter int B_W      = 16,
    parameter bit B_SIGNED = 1'b1,
    parameter int P_W      = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [A_W-1:0] a_i,
    input  logic        [B_W-1:0] b_i,
    output logic signed [P_W-1:0] p_o
);

    logic signed [B_W:0]   b_ext;
    logic signed [P_W-1:0] p_d;

    // P_W is sized to hold the exact product, so the wrap-free result
    // falls out of multiplying the sign-extended operands at that width.
    always_comb begin
        b_ext = B_SIGNED ? {b_i[B_W-1], b_i} : {1'b0, b_i};
        p_d   = P_W'(a_i) * P_W'(b_ext);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_o <= '0;
        end else begin
            p_o <= p_d;
        end
    end

endmodule

// File: rtl/mpemu_scale.sv
// Six-stage signed sample-by-Q8.24-gain multiplier; output is the product
// shifted right by FRAC_BITS with floor truncation and no saturation.
module mpemu_scale #(
    parameter int A_WIDTH   = 24,
    parameter int B_WIDTH   = 32,
    parameter int FRAC_BITS = 24,
    parameter int P_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [A_WIDTH-1:0] mpcand_i,
    input  logic signed [B_WIDTH-1:0] scale_i,
    output logic signed [P_WIDTH-1:0] mprod_o
);
    import mpemu_scale_pkg::*;

    logic signed [A_WIDTH-1:0] delayed_a1;
    logic signed [A_WIDTH-1:0] delayed_a2;
    logic signed [B_WIDTH-1:0] delayed_b1;
    logic signed [B_WIDTH-1:0] delayed_b2;
    logic signed [PP_LO_W-1:0] pp_lo;
    logic signed [PP_HI_W-1:0] pp_hi;
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [SUM_W-1:0]   sum_q;
    logic signed [P_WIDTH-1:0] scaled_d;
    logic signed [P_WIDTH-1:0] scaled_q;

    // Stages 1 and 2: operand delay registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delayed_a1 <= '0;
            delayed_b1 <= '0;
            delayed_a2 <= '0;
            delayed_b2 <= '0;
        end else begin
            delayed_a1 <= mpcand_i;
            delayed_b1 <= scale_i;
            delayed_a2 <= delayed_a1;
            delayed_b2 <= delayed_b1;
        end
    end

    // Stage 3: partial products, low half of the scale is magnitude-only
    mpemu_pp #(
        .A_W      (A_WIDTH),
        .B_W      (SPLIT_W),
        .B_SIGNED (1'b0),
        .P_W      (PP_LO_W)
    ) u_pp_lo (
        .clk (clk),
        .rst (rst),
        .a_i (delayed_a2),
        .b_i (delayed_b2[SPLIT_W-1:0]),
        .p_o (pp_lo)
    );

    mpemu_pp #(
        .A_W      (A_WIDTH),
        .B_W      (B_WIDTH - SPLIT_W),
        .B_SIGNED (1'b1),
        .P_W      (PP_HI_W)
    ) u_pp_hi (
        .clk (clk),
        .rst (rst),
        .a_i (delayed_a2),
        .b_i (delayed_b2[B_WIDTH-1:SPLIT_W]),
        .p_o (pp_hi)
    );

    // Stage 4 recombines at full width, stage 5 drops the fraction
    always_comb begin
        sum_d    = (SUM_W'(pp_hi) <<< SPLIT_W) + SUM_W'(pp_lo);
        scaled_d = sum_q[FRAC_BITS +: P_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= '0;
            scaled_q <= '0;
            mprod_o  <= '0;
        end else begin
            sum_q    <= sum_d;
            scaled_q <= scaled_d;
            mprod_o  <= scaled_q;
        end
    end

endmodule

// File: tb/tb_mpemu_scale.sv
// Scoreboard bench for mpemu_scale: stimulus pushes expected products with
// their due edge, a negedge monitor pops and compares them.
module tb_mpemu_scale;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] mpcand_i;
    logic signed [31:0] scale_i;
    logic signed [31:0] mprod_o;

    always #5 clk = ~clk;

    mpemu_scale dut (
        .clk      (clk),
        .rst      (rst),
        .mpcand_i (mpcand_i),
        .scale_i  (scale_i),
        .mprod_o  (mprod_o)
    );

    typedef struct {
        logic [31:0] exp;
        int          due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    // Reference: floor(a*b / 2^24), reduced mod 2^32.
    function automatic logic [31:0] golden(input logic signed [23:0] a,
                                           input logic signed [31:0] b);
        longint p;
        longint unit;
        longint q;
        p    = longint'(a) * longint'(b);
        unit = 64'sd16777216;
        q    = p / unit;
        if (p < 0 && (p % unit) != 0) q = q - 1;
        return q[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Called between edges; operands are captured on the next edge.
    task automatic drive(input logic [23:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        exp_t e;
        mpcand_i = a;
        scale_i  = b;
        e.exp = exp;
        e.due = edge_cnt + 6;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sb.size() > 0) begin
                if (sb[0].due == edge_cnt) begin
                    e = sb.pop_front();
                    check(e.tag, mprod_o, e.exp);
                end else if (sb[0].due > edge_cnt) begin
                    check("fill_zero", mprod_o, 32'h0);
                end else begin
                    e = sb.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: result missed, due edge %0d now %0d", e.tag, e.due, edge_cnt);
                end
            end
        end
    end

    initial begin
        logic [23:0] ra;
        logic [31:0] rb;

        rst      = 1'b1;
        mpcand_i = '0;
        scale_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", mprod_o, 32'h0);
        #1;
        rst = 1'b0;

        drive(24'h123456, 32'h01000000, 32'h00123456, "unity");
        drive(24'h800000, 32'h01000000, 32'hFF800000, "neg_full_unity");
        drive(24'h000003, 32'h00800000, 32'h00000001, "pos_half_floor");
        drive(24'hFFFFFD, 32'h00800000, 32'hFFFFFFFE, "neg_half_floor");
        drive(24'h7FFFFF, 32'h7FFFFFFF, 32'h3FFFFF7F, "max_max");
        drive(24'h800000, 32'h80000000, 32'h40000000, "min_min");
        drive(24'h7FFFFF, 32'h80000000, 32'hC0000080, "max_min");
        drive(24'hABCDEF, 32'h00000000, 32'h00000000, "scale_zero");
        drive(24'h000000, 32'hDEADBEEF, 32'h00000000, "mpcand_zero");
        drive(24'h000001, 32'hFFFFFFFF, 32'hFFFFFFFF, "tiny_neg");

        for (int i = 0; i < 100; i++) begin
            ra = 24'($urandom);
            rb = $urandom;
            case (i % 10)
                3: rb = {rb[31], 31'h0} | 32'($urandom_range(0, 255));
                7: ra = {ra[23], 23'h0};
                default: ;
            endcase
            drive(ra, rb, golden(ra, rb), "rand");
        end

        // Mid-stream asynchronous reset: everything in flight is dropped.
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", mprod_o, 32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            ra = 24'($urandom);
            rb = $urandom;
            drive(ra, rb, golden(ra, rb), "post_rst");
        end

        repeat (8) @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mpemu_scale.md
MPEMU_SCALE -- requirements
Module: mpemu_scale

Interface
REQ-001 Parameter A_WIDTH, default 24: multiplicand width, signed two's complement.
REQ-002 Parameter B_WIDTH, default 32: scale width, signed Q8.24 fixed point; 32'h01_000000 = 1.0.
REQ-003 Parameter FRAC_BITS, default 24: fractional bits of the scale, discarded from the product.
REQ-004 Parameter P_WIDTH, default 32: product output width.
REQ-005 Only the default parameter values SHALL be required to work; other values need not be supported.
REQ-006 Port clk, input, 1: single clock; all registers on the rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port mpcand_i, input, 24: signed sample, sampled every clock.
REQ-009 Port scale_i, input, 32: signed Q8.24 gain, sampled every clock.
REQ-010 Port mprod_o, output, 32: signed scaled product, registered.

Function
REQ-011 mprod_o SHALL equal bits [55:24] of the full 56-bit signed product mpcand_i*scale_i, i.e. an arithmetic shift right by 24 that truncates toward minus infinity.
REQ-012 The block SHALL NOT round or saturate; the excess integer bits are dropped.
REQ-013 Latency SHALL be exactly 6 clocks: operands present before rising edge k appear on mprod_o after edge k+5, stable through edge k+6.
REQ-014 The pipeline SHALL be fully pipelined: it accepts new operands every clock, with no valid or enable signals and no stalls.
REQ-015 Stage 1 SHALL register the operands into delayed_a1/delayed_b1.
REQ-016 Stage 2 SHALL register them again into delayed_a2/delayed_b2, kept under these names for debug visibility.
REQ-017 Stage 3 SHALL form two partial products: pp_lo = a * zero-extended b[15:0] (41-bit signed) and pp_hi = a * signed b[31:16] (40-bit signed).
REQ-018 Stage 4 SHALL compute the sum (pp_hi <<< 16) + pp_lo, sign-extended to 56 bits.
REQ-019 Stage 5 SHALL register bits [55:24] of the sum.
REQ-020 Stage 6 SHALL register the stage-5 value onto mprod_o.
REQ-021 Operand extremes SHALL be exact: 0x800000 * 0x80000000 gives 0x40000000, with no overflow of any intermediate.
REQ-022 Consecutive results SHALL emerge in input order, one per clock, with no bubbles.

Reset
REQ-023 While rst=1, all pipeline registers, including mprod_o, SHALL be 0 immediately without waiting for a clock edge.
REQ-024 After rst falls, mprod_o SHALL stay 0 until the first post-reset operands have travelled the 6 stages.
REQ-025 A reset asserted mid-stream SHALL discard all in-flight products; no stale result may appear after release.

Structure
REQ-026 A shared package SHALL hold the constants MPEMU_LATENCY=6, A_WIDTH, B_WIDTH, FRAC_BITS, P_WIDTH and the scale constant SCALE_UNITY=32'h01_000000, for use by the mixer sequencer.
REQ-027 The sub-module mpemu_pp SHALL be used: a registered signed-by-signed/unsigned partial-product multiplier instantiated twice for stage 3.
REQ-028 All other logic SHALL be inline in mpemu_scale.

Verification
REQ-029 Reset, then mpcand_i=0x123456 with scale_i=0x01000000 at edge 0 -> mprod_o=0x00123456 after edge 5, and 0 before that.
REQ-030 mpcand_i=0x800000 with scale 1.0 -> 0xFF800000; mpcand_i=0x000003 with scale_i=0x00800000 -> 0x00000001; mpcand_i=0xFFFFFD with scale 0.5 -> 0xFFFFFFFE (floor of -1.5).
REQ-031 Extremes: 0x7FFFFF*0x7FFFFFFF -> 0x3FFFFF7F; 0x800000*0x80000000 -> 0x40000000; 0x7FFFFF*0x80000000 -> 0xC0000080.
REQ-032 Stream 100 random operand pairs, one per clock -> each mprod_o equals the golden floor((a*b)/2^24) mod 2^32, exactly 6 clocks later and in order.
REQ-033 Assert rst asynchronously between edges mid-stream -> mprod_o goes to 0 before the next edge; after release, 0 is output until new operands appear 6 clocks later.
REQ-034 Scale 0 with any mpcand_i -> 0; mpcand_i 0 with any scale_i -> 0.
